// File: rtl/credit_link_allocator_pkg.sv
// Shared definitions for the NIC output-link allocator.
// Contents:
//   clog2        - ceiling log2, used to size id fields (minimum 1 bit)
//   N_OF_VN, N_OF_VC, DEF_* - default sizing of the NIC
//   la_state_t   - link allocator state: LA_ARB (free) / LA_LOCKED (packet in flight)
package credit_link_allocator_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   localparam int N_OF_VN               = 2;
   localparam int N_OF_VC               = 3;
   localparam int DEF_N_TOT_OF_VC       = N_OF_VN * N_OF_VC;
   localparam int DEF_N_FIFO_OUT_BUFFER = 6;

   typedef enum logic {
      LA_ARB    = 1'b0,
      LA_LOCKED = 1'b1
   } la_state_t;

endpackage

// File: rtl/credit_link_allocator_rr_arbiter.sv
// Combinational N-request round-robin arbiter.
// Scans req starting at index ptr, wrapping, and grants the first set bit.
// Ports:
//   req     in  N     request vector
//   ptr     in  ID_W  highest-priority index this cycle
//   gnt     out N     one-hot grant (all zero when nothing requests)
//   gnt_id  out ID_W  binary index of the grant (0 when nothing requests)
//   gnt_vld out 1     some request was granted
module rr_arbiter #(
   parameter int N    = 6,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_vld
);

   always_comb begin
      int idx;
      gnt     = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/credit_link_allocator.sv
// Shares the NIC output link among the out-buffers, one flit per cycle.
// Round-robin among packet heads; once a multi-flit head is granted the link
// stays with that buffer until its tail goes. Per-VC credit counters gate
// eligibility. The grant is combinational from inputs and registered state.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   r_la_i                     per-buffer flit-ready
//   is_head_i / is_tail_i      per-buffer head/tail flags of the waiting flit
//   vc_id_i                    per-buffer one-hot downstream VC (slice i)
//   credit_signal_i            per-VC credit return strobe
//   g_la_o                     a flit is granted this cycle
//   g_la_fifo_out_buffer_id_o  binary id of the granted buffer
//   g_la_onehot_o              one-hot grant, used as pop strobe
//   credit_avail_o             per-VC counter != 0
//   credit_err_o               sticky: credit returned to a full counter
module credit_link_allocator
   import credit_link_allocator_pkg::*;
#(
   parameter int N_FIFO_OUT_BUFFER      = DEF_N_FIFO_OUT_BUFFER,
   parameter int N_BITS_FIFO_OUT_BUFFER = clog2(N_FIFO_OUT_BUFFER),
   parameter int N_TOT_OF_VC            = DEF_N_TOT_OF_VC,
   parameter int N_BITS_CREDIT          = 4,
   parameter int MAX_CREDIT             = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_FIFO_OUT_BUFFER-1:0]         r_la_i,
   input  logic [N_FIFO_OUT_BUFFER-1:0]         is_head_i,
   input  logic [N_FIFO_OUT_BUFFER-1:0]         is_tail_i,
   input  logic [N_FIFO_OUT_BUFFER*N_TOT_OF_VC-1:0] vc_id_i,
   input  logic [N_TOT_OF_VC-1:0]               credit_signal_i,
   output logic                                 g_la_o,
   output logic [N_BITS_FIFO_OUT_BUFFER-1:0]    g_la_fifo_out_buffer_id_o,
   output logic [N_FIFO_OUT_BUFFER-1:0]         g_la_onehot_o,
   output logic [N_TOT_OF_VC-1:0]               credit_avail_o,
   output logic                                 credit_err_o
);

   localparam int N  = N_FIFO_OUT_BUFFER;
   localparam int V  = N_TOT_OF_VC;
   localparam int IW = N_BITS_FIFO_OUT_BUFFER;
   localparam logic [N_BITS_CREDIT-1:0] CMAX = N_BITS_CREDIT'(MAX_CREDIT);

   logic [V-1:0]  vc_slice [N];
   logic [N-1:0]  elig;
   logic [N-1:0]  arb_req;
   logic [N-1:0]  arb_gnt;
   logic [IW-1:0] arb_id;
   logic          arb_vld;

   la_state_t     state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [IW-1:0] owner, owner_nxt;

   logic          gnt;
   logic [IW-1:0] gnt_id;
   logic [N-1:0]  gnt_oh;
   logic [V-1:0]  grant_vc;
   logic [V-1:0]  over_ret;
   logic          err;

   // A malformed VC slice (zero or multi-hot) can never become eligible.
   for (genvar i = 0; i < N; i++) begin : g_elig
      assign vc_slice[i] = vc_id_i[i*V +: V];
      assign elig[i]     = r_la_i[i] && $onehot(vc_slice[i]) &&
                           (|(vc_slice[i] & credit_avail_o));
   end

   // Only packet heads may open a new arbitration round.
   assign arb_req = elig & is_head_i;

   rr_arbiter #(
      .N    (N),
      .ID_W (IW)
   ) u_rr (
      .req     (arb_req),
      .ptr     (ptr),
      .gnt     (arb_gnt),
      .gnt_id  (arb_id),
      .gnt_vld (arb_vld)
   );

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      gnt       = 1'b0;
      gnt_id    = '0;
      gnt_oh    = '0;
      if (!rst) begin
         case (state)
            LA_ARB: begin
               if (arb_vld) begin
                  gnt     = 1'b1;
                  gnt_id  = arb_id;
                  gnt_oh  = arb_gnt;
                  ptr_nxt = (arb_id == IW'(N-1)) ? '0 : arb_id + IW'(1);
                  if (!is_tail_i[arb_id]) begin
                     owner_nxt = arb_id;
                     state_nxt = LA_LOCKED;
                  end
               end
            end
            LA_LOCKED: begin
               // Link idles rather than serving anyone but the owner.
               if (elig[owner]) begin
                  gnt           = 1'b1;
                  gnt_id        = owner;
                  gnt_oh[owner] = 1'b1;
                  if (is_tail_i[owner]) state_nxt = LA_ARB;
               end
            end
            default: state_nxt = LA_ARB;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LA_ARB;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      grant_vc = '0;
      for (int i = 0; i < N; i++)
         if (gnt_oh[i]) grant_vc = grant_vc | vc_slice[i];
   end

   // Grant and return on the same VC in one cycle cancel out.
   for (genvar v = 0; v < V; v++) begin : g_credit
      logic [N_BITS_CREDIT-1:0] cnt;
      always_ff @(posedge clk) begin
         if (rst)
            cnt <= CMAX;
         else if (grant_vc[v] && !credit_signal_i[v])
            cnt <= cnt - N_BITS_CREDIT'(1);
         else if (!grant_vc[v] && credit_signal_i[v] && cnt != CMAX)
            cnt <= cnt + N_BITS_CREDIT'(1);
      end
      assign credit_avail_o[v] = (cnt != '0);
      assign over_ret[v]       = credit_signal_i[v] && !grant_vc[v] && (cnt == CMAX);
   end

   always_ff @(posedge clk) begin
      if (rst)            err <= 1'b0;
      else if (|over_ret) err <= 1'b1;
   end

   assign g_la_o                    = gnt;
   assign g_la_fifo_out_buffer_id_o = gnt_id;
   assign g_la_onehot_o             = gnt_oh;
   assign credit_err_o              = err;

endmodule
